// File: rtl/ad9361_ctrl_bank_pkg.sv
// Shared definitions for the AD9361 control register bank: register offsets,
// sequencer state encodings and defaults.
package ad9361_ctrl_bank_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEQ_W  = 3;

  localparam logic [ADDR_W-1:0] AD9361REG_BASE = 18'h0_4000;

  localparam logic [ADDR_W-1:0] AD9361_RST        = 18'h100;
  localparam logic [ADDR_W-1:0] AD9361_EN         = 18'h110;
  localparam logic [ADDR_W-1:0] AD9361_TRX_REQ    = 18'h120;
  localparam logic [ADDR_W-1:0] AD9361_EN_AGC     = 18'h130;
  localparam logic [ADDR_W-1:0] AD9361_RF_CTRL_IN = 18'h140;
  localparam logic [ADDR_W-1:0] AD9361_GUARD      = 18'h150;
  localparam logic [ADDR_W-1:0] AD9361_STATUS     = 18'h160;

  localparam logic [SEQ_W-1:0] SEQ_RX      = 3'd0;
  localparam logic [SEQ_W-1:0] SEQ_SW_ON   = 3'd1;
  localparam logic [SEQ_W-1:0] SEQ_TRX_ON  = 3'd2;
  localparam logic [SEQ_W-1:0] SEQ_TX      = 3'd3;
  localparam logic [SEQ_W-1:0] SEQ_PA_OFF  = 3'd4;
  localparam logic [SEQ_W-1:0] SEQ_TRX_OFF = 3'd5;

  localparam int unsigned GUARD_DEF = 16;

endpackage

// File: rtl/ad9361_ctrl_bank_if.sv
// Register bus shared by the peripheral register blocks (18-bit address, 32-bit data).
interface ad9361_ctrl_bank_if;
  import ad9361_ctrl_bank_pkg::*;

  logic              en;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output en, output wen, output addr, output din, input dout);
  modport slave  (input en, input wen, input addr, input din, output dout);
endinterface

// File: rtl/ad9361_ctrl_bank_trx_seq.sv
// Single-channel TX/RX turnaround sequencer: orders rf_sw, tx_rx and pa_en
// with a guard interval latched on entry to every transient state.
module trx_seq
  import ad9361_ctrl_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [CNT_W-1:0] guard,
  output logic             rf_sw,
  output logic             tx_rx,
  output logic             pa_en,
  output logic [SEQ_W-1:0] state
);

  logic [SEQ_W-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_c;
  logic             rf_sw_q, tx_rx_q, pa_en_q;
  logic             rf_sw_d, tx_rx_d, pa_en_d;

  // State, dwell counter and outputs; reset drops every output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_RX;
      cnt_q   <= '0;
      rf_sw_q <= 1'b0;
      tx_rx_q <= 1'b0;
      pa_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rf_sw_q <= rf_sw_d;
      tx_rx_q <= tx_rx_d;
      pa_en_q <= pa_en_d;
    end
  end

  // req is only looked at in the two steady states; transients run to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    case (state_q)
      SEQ_RX: begin
        if (req) begin
          state_d = SEQ_SW_ON;
          load_c  = 1'b1;
        end
      end
      SEQ_SW_ON: begin
        if (cnt_q == '0) begin
          state_d = SEQ_TRX_ON;
          load_c  = 1'b1;
        end
      end
      SEQ_TRX_ON: begin
        if (cnt_q == '0) state_d = SEQ_TX;
      end
      SEQ_TX: begin
        if (!req) begin
          state_d = SEQ_PA_OFF;
          load_c  = 1'b1;
        end
      end
      SEQ_PA_OFF: begin
        if (cnt_q == '0) begin
          state_d = SEQ_TRX_OFF;
          load_c  = 1'b1;
        end
      end
      SEQ_TRX_OFF: begin
        if (cnt_q == '0) state_d = SEQ_RX;
      end
      default: state_d = SEQ_RX;
    endcase
    // Dwell of max(guard,1) cycles counts down to zero from guard-1.
    if (load_c) cnt_d = (guard == '0) ? '0 : guard - CNT_W'(1);

    rf_sw_d = (state_d != SEQ_RX);
    tx_rx_d = (state_d == SEQ_TRX_ON) || (state_d == SEQ_TX) || (state_d == SEQ_PA_OFF);
    pa_en_d = (state_d == SEQ_TX);
  end

  assign rf_sw = rf_sw_q;
  assign tx_rx = tx_rx_q;
  assign pa_en = pa_en_q;
  assign state = state_q;

endmodule

// File: rtl/ad9361_ctrl_bank.sv
// AD9361 control register bank: register file with registered readback,
// reset pulse generator and one TX/RX sequencer per channel.
module ad9361_ctrl_bank
  import ad9361_ctrl_bank_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE      = AD9361REG_BASE,
  parameter int unsigned       NCH       = 2,
  parameter int unsigned       CTRL_W    = 4,
  parameter int unsigned       CNT_W     = 16,
  parameter int unsigned       GUARD_DEF = ad9361_ctrl_bank_pkg::GUARD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  ad9361_ctrl_bank_if.slave        bus,
  output logic                     ad9361_rstb,
  output logic [NCH-1:0]           ad9361_en,
  output logic [NCH-1:0]           ad9361_en_agc,
  output logic [NCH-1:0]           ad9361_tx_rx,
  output logic [NCH*CTRL_W-1:0]    rf_ctrl_in,
  output logic [NCH-1:0]           rf_sw,
  output logic [NCH-1:0]           pa_en
);

  localparam int unsigned RFC_W  = NCH * CTRL_W;
  localparam int unsigned STAT_W = SEQ_W * NCH;

  logic [ADDR_W-1:0] off_c;
  logic              wr_c, rd_c, rst_load_c, busy_c;
  logic [CNT_W-1:0]  rst_n_c;

  logic [NCH-1:0]    en_q, req_q, agc_q;
  logic [RFC_W-1:0]  rfc_q;
  logic [CNT_W-1:0]  guard_q;
  logic [CNT_W-1:0]  rst_cnt_q;
  logic              rstb_q;
  logic [DATA_W-1:0] dout_q, rd_data_c;
  logic [STAT_W-1:0] status_c;
  logic              unused_c;

  assign off_c      = bus.addr - BASE;
  assign wr_c       = bus.en & bus.wen;
  assign rd_c       = bus.en & ~bus.wen;
  assign rst_n_c    = bus.din[CNT_W-1:0];
  assign rst_load_c = wr_c && (off_c == AD9361_RST) && (rst_n_c != '0);
  assign busy_c     = (rst_cnt_q != '0) | ~rstb_q;
  assign unused_c   = &{1'b0, bus.din};

  // Writable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= '0;
      req_q   <= '0;
      agc_q   <= '0;
      rfc_q   <= '0;
      guard_q <= CNT_W'(GUARD_DEF);
    end else if (wr_c) begin
      case (off_c)
        AD9361_EN:         en_q    <= bus.din[NCH-1:0];
        AD9361_TRX_REQ:    req_q   <= bus.din[NCH-1:0];
        AD9361_EN_AGC:     agc_q   <= bus.din[NCH-1:0];
        AD9361_RF_CTRL_IN: rfc_q   <= bus.din[RFC_W-1:0];
        AD9361_GUARD:      guard_q <= bus.din[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Reset pulse: a rewrite while rstb is already low keeps it low without a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt_q <= '0;
      rstb_q    <= 1'b1;
    end else begin
      if (rst_load_c)            rst_cnt_q <= rst_n_c;
      else if (rst_cnt_q != '0)  rst_cnt_q <= rst_cnt_q - CNT_W'(1);
      rstb_q <= (rst_cnt_q == '0) & ~(rst_load_c & ~rstb_q);
    end
  end

  // Readback mux; unmapped offsets and unused upper bits read as zero.
  always_comb begin
    rd_data_c = '0;
    case (off_c)
      AD9361_RST:        rd_data_c = DATA_W'(busy_c);
      AD9361_EN:         rd_data_c = DATA_W'(en_q);
      AD9361_TRX_REQ:    rd_data_c = DATA_W'(req_q);
      AD9361_EN_AGC:     rd_data_c = DATA_W'(agc_q);
      AD9361_RF_CTRL_IN: rd_data_c = DATA_W'(rfc_q);
      AD9361_GUARD:      rd_data_c = DATA_W'(guard_q);
      AD9361_STATUS:     rd_data_c = DATA_W'(status_c);
      default:           rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       dout_q <= '0;
    else if (rd_c) dout_q <= rd_data_c;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_seq
    trx_seq #(.CNT_W(CNT_W)) u_seq (
      .clk   (clk),
      .rst   (rst),
      .req   (req_q[c]),
      .guard (guard_q),
      .rf_sw (rf_sw[c]),
      .tx_rx (ad9361_tx_rx[c]),
      .pa_en (pa_en[c]),
      .state (status_c[SEQ_W*c +: SEQ_W])
    );
  end

  assign bus.dout      = dout_q;
  assign ad9361_rstb   = rstb_q;
  assign ad9361_en     = en_q;
  assign ad9361_en_agc = agc_q;
  assign rf_ctrl_in    = rfc_q;

endmodule

// File: tb/tb_ad9361_ctrl_bank.sv
// Bench for ad9361_ctrl_bank: scoreboarded readback plus per-cycle output
// comparison against a behavioural model, with directed timing checks.
module tb_ad9361_ctrl_bank;
  import ad9361_ctrl_bank_pkg::*;

  localparam int unsigned NCH    = 2;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam logic [17:0] BASE   = AD9361REG_BASE;

  logic clk = 1'b0;
  logic rst;
  logic                  ad9361_rstb;
  logic [NCH-1:0]        ad9361_en, ad9361_en_agc, ad9361_tx_rx, rf_sw, pa_en;
  logic [NCH*CTRL_W-1:0] rf_ctrl_in;

  ad9361_ctrl_bank_if bus ();

  ad9361_ctrl_bank #(
    .BASE(BASE), .NCH(NCH), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .GUARD_DEF(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ad9361_rstb(ad9361_rstb), .ad9361_en(ad9361_en), .ad9361_en_agc(ad9361_en_agc),
    .ad9361_tx_rx(ad9361_tx_rx), .rf_ctrl_in(rf_ctrl_in), .rf_sw(rf_sw), .pa_en(pa_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is a level 0..3 = number of outputs asserted in the order
  // rf_sw, tx_rx, pa_en, plus a direction of travel and the cycle of its next step.
  int                    cyc;
  logic [NCH-1:0]        m_en, m_req, m_agc;
  logic [NCH*CTRL_W-1:0] m_rfc;
  logic [CNT_W-1:0]      m_guard;
  int                    lvl [NCH];
  int                    dir [NCH];
  int                    nxt [NCH];
  int                    p_ws, p_lo, p_end, m_g;
  logic                  m_rstb, m_busy, rd_flag;
  logic [17:0]           m_off;
  logic [31:0]           exp_q[$];
  logic [31:0]           hold_dout;

  function automatic logic [2:0] st_code(input int l, input int d);
    if (l == 0) return 3'd0;
    if (l == 3) return 3'd3;
    if (d > 0)  return 3'(l);
    return (l == 2) ? 3'd4 : 3'd5;
  endfunction

  function automatic logic [31:0] model_read(input logic [17:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      AD9361_RST:        v = 32'(m_busy);
      AD9361_EN:         v = 32'(m_en);
      AD9361_TRX_REQ:    v = 32'(m_req);
      AD9361_EN_AGC:     v = 32'(m_agc);
      AD9361_RF_CTRL_IN: v = 32'(m_rfc);
      AD9361_GUARD:      v = 32'(m_guard);
      AD9361_STATUS:     for (int c = 0; c < NCH; c++) v[3*c +: 3] = st_code(lvl[c], dir[c]);
      default:           v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    cyc = 0; m_en = '0; m_req = '0; m_agc = '0; m_rfc = '0; m_guard = CNT_W'(16);
    for (int c = 0; c < NCH; c++) begin lvl[c] = 0; dir[c] = 0; nxt[c] = 0; end
    p_ws = -100; p_lo = -100; p_end = -200;
    m_rstb = 1'b1; m_busy = 1'b0; rd_flag = 1'b0; hold_dout = '0;
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        cyc++;
        m_off = bus.addr - BASE;
        rd_flag = 1'b0;
        if (bus.en && !bus.wen) begin
          exp_q.push_back(model_read(m_off));
          rd_flag = 1'b1;
        end
        m_g = (m_guard == '0) ? 1 : int'(m_guard);
        for (int c = 0; c < NCH; c++) begin
          if (dir[c] == 0) begin
            int tgt;
            tgt = m_req[c] ? 3 : 0;
            if (tgt != lvl[c]) begin
              dir[c] = (tgt > lvl[c]) ? 1 : -1;
              lvl[c] += dir[c];
              nxt[c] = cyc + m_g;
            end
          end else if (cyc == nxt[c]) begin
            lvl[c] += dir[c];
            if (lvl[c] == 0 || lvl[c] == 3) dir[c] = 0;
            else nxt[c] = cyc + m_g;
          end
        end
        if (bus.en && bus.wen && m_off == AD9361_RST && bus.din[CNT_W-1:0] != '0) begin
          if (!m_busy) begin p_ws = cyc; p_lo = cyc + 1; end
          p_end = cyc + int'(bus.din[CNT_W-1:0]);
        end
        m_busy = (cyc >= p_ws) && (cyc <= p_end);
        m_rstb = !((cyc >= p_lo) && (cyc <= p_end));
        if (bus.en && bus.wen) begin
          case (m_off)
            AD9361_EN:         m_en    = bus.din[NCH-1:0];
            AD9361_TRX_REQ:    m_req   = bus.din[NCH-1:0];
            AD9361_EN_AGC:     m_agc   = bus.din[NCH-1:0];
            AD9361_RF_CTRL_IN: m_rfc   = bus.din[NCH*CTRL_W-1:0];
            AD9361_GUARD:      m_guard = bus.din[CNT_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : mon
    logic [NCH-1:0] e_rf, e_trx, e_pa;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        e_rf[c]  = lvl[c] >= 1;
        e_trx[c] = lvl[c] >= 2;
        e_pa[c]  = lvl[c] == 3;
      end
      if (rd_flag) begin
        rd_flag = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: read seen with no expected entry (t=%0t)", $time);
        end else hold_dout = exp_q.pop_front();
      end
      check("dout",       bus.dout,              hold_dout);
      check("rf_sw",      32'(rf_sw),            32'(e_rf));
      check("tx_rx",      32'(ad9361_tx_rx),     32'(e_trx));
      check("pa_en",      32'(pa_en),            32'(e_pa));
      check("en",         32'(ad9361_en),        32'(m_en));
      check("en_agc",     32'(ad9361_en_agc),    32'(m_agc));
      check("rf_ctrl_in", 32'(rf_ctrl_in),       32'(m_rfc));
      check("rstb",       32'(ad9361_rstb),      32'(m_rstb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_op(input logic w, input logic [17:0] a, input logic [31:0] d);
    bus.en = 1'b1; bus.wen = w; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.en = 1'b0; bus.wen = 1'b0;
  endtask

  task automatic wr(input logic [17:0] off, input logic [31:0] d);
    bus_op(1'b1, 18'(BASE + off), d);
  endtask

  task automatic rd(input logic [17:0] off);
    bus_op(1'b0, 18'(BASE + off), '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [17:0] offs [9];

  initial begin
    offs[0] = AD9361_RST;    offs[1] = AD9361_EN;         offs[2] = AD9361_TRX_REQ;
    offs[3] = AD9361_EN_AGC; offs[4] = AD9361_RF_CTRL_IN; offs[5] = AD9361_GUARD;
    offs[6] = AD9361_STATUS; offs[7] = 18'h170;           offs[8] = 18'h000;
    rst = 1'b1;
    bus.en = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.din = '0;
    idle(2);
    check("reset_rstb", 32'(ad9361_rstb), 32'd1);
    check("reset_pa_en", 32'(pa_en), 32'd0);
    rst = 1'b0;
    idle(1);

    // Readback after reset.
    for (int i = 0; i < 8; i++) rd(offs[i]);
    idle(2);

    // GUARD=3, ch0 to TX: rf_sw at k+1, tx_rx at k+4, pa_en at k+7.
    wr(AD9361_GUARD, 32'd3);
    wr(AD9361_TRX_REQ, 32'b01);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      check("g3_rf_sw0", 32'(rf_sw[0]),        32'(j >= 1));
      check("g3_tx_rx0", 32'(ad9361_tx_rx[0]), 32'(j >= 4));
      check("g3_pa_en0", 32'(pa_en[0]),        32'(j >= 7));
      check("g3_ch1",    32'({rf_sw[1], ad9361_tx_rx[1], pa_en[1]}), 32'd0);
    end
    rd(AD9361_STATUS);

    // Drop the request mid-sequence (in TRX_ON); the sequence finishes TX then unwinds.
    wr(AD9361_TRX_REQ, 32'b00);
    idle(12);
    wr(AD9361_TRX_REQ, 32'b01);
    idle(4);
    wr(AD9361_TRX_REQ, 32'b00);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check("unwind_pa_en", 32'(pa_en[0]),        32'(j == 2));
      check("unwind_tx_rx", 32'(ad9361_tx_rx[0]), 32'(j <= 5));
      check("unwind_rf_sw", 32'(rf_sw[0]),        32'(j <= 8));
    end
    rd(AD9361_STATUS);

    // GUARD=0: each transient lasts one cycle.
    wr(AD9361_GUARD, 32'd0);
    wr(AD9361_TRX_REQ, 32'b11);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("g0_rf_sw", 32'(rf_sw),        32'(j >= 1 ? 2'b11 : 2'b00));
      check("g0_tx_rx", 32'(ad9361_tx_rx), 32'(j >= 2 ? 2'b11 : 2'b00));
      check("g0_pa_en", 32'(pa_en),        32'(j >= 3 ? 2'b11 : 2'b00));
    end

    // Reset pulse N=5, then N=0 (no effect), then a restart mid-pulse.
    wr(AD9361_RST, 32'd5);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      check("pulse5_rstb", 32'(ad9361_rstb), 32'(j > 5));
    end
    wr(AD9361_RST, 32'd0);
    idle(2);
    check("pulse0_rstb", 32'(ad9361_rstb), 32'd1);
    wr(AD9361_RST, 32'd5);
    rd(AD9361_RST);
    idle(1);
    wr(AD9361_RST, 32'd2);
    check("restart_rstb", 32'(ad9361_rstb), 32'd0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check("restart2_rstb", 32'(ad9361_rstb), 32'(j > 2));
    end
    rd(AD9361_RST);

    // Randomized register traffic.
    for (int i = 0; i < 400; i++) begin
      int idx;
      logic [31:0] d;
      logic [17:0] a;
      idx = $urandom_range(0, 8);
      d   = $urandom;
      if (idx == 0) d = 32'($urandom_range(0, 6));
      if (idx == 5) d = 32'($urandom_range(0, 4));
      a = (idx == 8) ? 18'($urandom) : 18'(BASE + offs[idx]);
      bus_op(1'($urandom_range(0, 1)), a, d);
      idle($urandom_range(0, 3));
    end
    idle(20);

    // Asynchronous reset while the PA is on.
    wr(AD9361_GUARD, 32'd1);
    wr(AD9361_TRX_REQ, 32'b01);
    idle(6);
    check("pre_rst_pa_en", 32'(pa_en[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_pa_en", 32'(pa_en),        32'd0);
    check("async_tx_rx", 32'(ad9361_tx_rx), 32'd0);
    check("async_rf_sw", 32'(rf_sw),        32'd0);
    check("async_rstb",  32'(ad9361_rstb),  32'd1);
    check("async_dout",  bus.dout,          32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    rd(AD9361_GUARD);
    rd(18'h170);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
